key_event_sequencer: RTL and testbench
======================================

// Module: key_event_sequencer
// PURPOSE
//  Sequences the 8-lane key-state register from the raw PS/2 byte stream.
//  Parses make, break (F0) and extended (E0) prefixes, filters typematic repeats
//  and drops non-lane keys. Emits one-cycle load events (key_code, key_press):
//  key_code is 8'h00 on every idle cycle, so the key-state register decodes no
//  lane and loads nothing. Sits between the PS/2 byte receiver and the
//  key-state register.
// PARAMETERS
//  TIMEOUT_CYCLES  2_500_000  idle cycles allowed mid-sequence (50 ms @ 50 MHz) before abort
// PORTS
//  Clk          in   1  system clock; all logic on rising edge
//  Reset        in   1  synchronous, active-high reset
//  ps2_byte     in   8  received scancode byte; valid only while ps2_valid=1
//  ps2_valid    in   1  one-cycle strobe per received byte; may assert on consecutive cycles
//  key_code     out  8  lane make code during a key_strobe cycle, else 8'h00
//  key_press    out  1  1=make, 0=break; meaningful only with key_strobe
//  key_strobe   out  1  one-cycle event pulse
//  held         out  8  shadow lane state {A,S,D,F,J,K,L,;}; bit7=A, bit0=;
//  err_timeout  out  1  one-cycle pulse when a partial sequence is aborted
// BEHAVIOUR
//  - Reset: state=IDLE; key_code=8'h00; key_press=0; key_strobe=0; held=8'h00;
//    err_timeout=0; timeout counter=0. Reset mid-sequence discards any prefix.
//  - Lanes and make codes: A=1C S=1B D=23 F=2B J=3B K=42 L=4B ;=4C. All other codes are non-lane.
//  - FSM, advanced only on ps2_valid:
//    IDLE:    F0->BRK; E0->EXT; AA/FA/EE/FE ignored (stay IDLE);
//             lane code with held[lane]=0 -> make event, stay IDLE;
//             lane code with held[lane]=1 -> typematic repeat, suppressed;
//             other codes ignored.
//    BRK:     any byte -> IDLE; lane code -> break event (emitted even if held=0);
//             non-lane code -> no event.
//    EXT:     F0->EXT_BRK; any other byte -> IDLE, no event (extended keys are never lanes).
//    EXT_BRK: any byte -> IDLE, no event.
//  - Event timing: registered outputs, latency exactly 1 cycle after the completing
//    ps2_valid. On the strobe cycle key_code=lane make code (break events also carry
//    the make code), key_press=1/0 and held[lane] updates on the same edge.
//    Back-to-back valid bytes each give their own event on successive cycles.
//  - held bit sets on a make event and clears on a break event. Only one lane changes per event.
//  - Timeout: the counter runs only in non-IDLE states. It clears on every ps2_valid
//    and on entry to IDLE, and increments on each cycle without ps2_valid.
//    On reaching TIMEOUT_CYCLES-1: next state=IDLE, err_timeout pulses 1 cycle, no event.
//    If ps2_valid arrives on that same cycle, the byte wins: it is processed, no timeout.
//  - Counter width $clog2(TIMEOUT_CYCLES); no wrap is possible.
// STRUCTURE
//  - Package key_pkg: state enum (IDLE,BRK,EXT,EXT_BRK); constants SC_BREAK=F0,
//    SC_EXT=E0, SC_BAT=AA, SC_ACK=FA, SC_ECHO=EE, SC_RESEND=FE; 8 lane make-code
//    constants; function lane_of(code)->{hit, idx[2:0]}. The key-state register shares this package.
//  - Sub-module ps2_watchdog: timeout counter with clear/enable inputs and an expire output.
//  - Top level: FSM, lane lookup, held register, output registers.
// TESTING
//  1 Reset: hold Reset 2 cycles -> all outputs 0, held=00. Then bytes 1C -> strobe, code=1C, press=1, held=80.
//  2 Make 1C, then 1C,1C (repeat) -> a single strobe; F0,1C -> strobe, code=1C, press=0, held=00.
//  3 Extended: E0,4B and E0,F0,4B -> no strobe, held unchanged. Next byte 4B -> make of L, held=02.
//  4 Back-to-back: valid on consecutive cycles 23,2B,F0,23 -> strobes on cycles n+1,n+2,n+4;
//    held 20->30->10. key_code=00 on every non-strobe cycle.
//  5 Timeout (TIMEOUT_CYCLES=16): F0 then 16 idle cycles -> err_timeout pulses once, state IDLE.
//    Next byte 42 -> make of K, not a break. A byte on the expiry cycle -> processed, no err.
//  6 Reset mid-sequence: F0, Reset 1 cycle, 3B -> make of J (press=1). held=08 only.

Source files
------------

// File: rtl/key_pkg.sv
// Shared scancode constants, FSM state type and lane lookup for the PS/2 key
// path; the key-state register decodes lanes with the same lane_of().
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;

    localparam logic [7:0] LANE_A    = 8'h1C;
    localparam logic [7:0] LANE_S    = 8'h1B;
    localparam logic [7:0] LANE_D    = 8'h23;
    localparam logic [7:0] LANE_F    = 8'h2B;
    localparam logic [7:0] LANE_J    = 8'h3B;
    localparam logic [7:0] LANE_K    = 8'h42;
    localparam logic [7:0] LANE_L    = 8'h4B;
    localparam logic [7:0] LANE_SEMI = 8'h4C;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } lane_t;

    // idx is the held[] bit: A is the MSB, ';' the LSB.
    function automatic lane_t lane_of(input logic [7:0] code);
        lane_t r;
        r.hit = 1'b1;
        r.idx = 3'd0;
        case (code)
            LANE_A:    r.idx = 3'd7;
            LANE_S:    r.idx = 3'd6;
            LANE_D:    r.idx = 3'd5;
            LANE_F:    r.idx = 3'd4;
            LANE_J:    r.idx = 3'd3;
            LANE_K:    r.idx = 3'd2;
            LANE_L:    r.idx = 3'd1;
            LANE_SEMI: r.idx = 3'd0;
            default:   r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_watchdog.sv
// Mid-sequence idle watchdog: counts cycles while enabled and flags expiry
// once TIMEOUT_CYCLES-1 idle cycles have accumulated.
module ps2_watchdog #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/key_event_sequencer.sv
// PS/2 byte-stream parser: turns make/break/extended sequences into one-cycle
// lane load events and keeps a shadow copy of the held lanes.
module key_event_sequencer
    import key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_valid,
    output logic [7:0] key_code,
    output logic       key_press,
    output logic       key_strobe,
    output logic [7:0] held,
    output logic       err_timeout
);

    state_t state, state_next;
    lane_t  lane;
    logic   expire;
    logic   ev_strobe, ev_press, ev_err;

    assign lane = lane_of(ps2_byte);

    ps2_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (Clk),
        .reset  (Reset),
        .clear  (ps2_valid || state == IDLE),
        .enable (state != IDLE),
        .expire (expire)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case statements can infer a latch.
    always_comb begin
        state_next = state;
        if (ps2_valid) begin
            case (state)
                IDLE: begin
                    if (ps2_byte == SC_BREAK)    state_next = BRK;
                    else if (ps2_byte == SC_EXT) state_next = EXT;
                end
                EXT:     state_next = (ps2_byte == SC_BREAK) ? EXT_BRK : IDLE;
                default: state_next = IDLE;
            endcase
        end else if (expire) begin
            state_next = IDLE;
        end
    end

    // A byte arriving on the expiry cycle takes priority over the abort.
    always_comb begin
        ev_strobe = 1'b0;
        ev_press  = 1'b0;
        ev_err    = 1'b0;
        if (ps2_valid) begin
            case (state)
                IDLE: begin
                    case (ps2_byte)
                        SC_BAT, SC_ACK, SC_ECHO, SC_RESEND: ;
                        default: begin
                            if (lane.hit && !held[lane.idx]) begin
                                ev_strobe = 1'b1;
                                ev_press  = 1'b1;
                            end
                        end
                    endcase
                end
                BRK:     ev_strobe = lane.hit;
                default: ;
            endcase
        end else begin
            ev_err = expire;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_code    <= 8'h00;
            key_press   <= 1'b0;
            key_strobe  <= 1'b0;
            held        <= 8'h00;
            err_timeout <= 1'b0;
        end else begin
            key_strobe  <= ev_strobe;
            key_code    <= ev_strobe ? ps2_byte : 8'h00;
            key_press   <= ev_press;
            err_timeout <= ev_err;
            if (ev_strobe) held[lane.idx] <= ev_press;
        end
    end

endmodule

// File: tb/tb_key_event_sequencer.sv
// Directed self-checking bench for key_event_sequencer with a short timeout.
module tb_key_event_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] ps2_byte;
    logic       ps2_valid;
    logic [7:0] key_code;
    logic       key_press;
    logic       key_strobe;
    logic [7:0] held;
    logic       err_timeout;

    int checks = 0;
    int passed = 0;

    key_event_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ps2_byte    (ps2_byte),
        .ps2_valid   (ps2_valid),
        .key_code    (key_code),
        .key_press   (key_press),
        .key_strobe  (key_strobe),
        .held        (held),
        .err_timeout (err_timeout)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_byte  = b;
        ps2_valid = 1'b1;
        tick();
        ps2_valid = 1'b0;
        ps2_byte  = 8'h00;
    endtask

    task automatic expect_event(input string tag, input logic [7:0] code,
                                input logic press, input logic [7:0] h);
        check({tag, " strobe"}, {7'd0, key_strobe}, 8'h01);
        check({tag, " code"},   key_code, code);
        check({tag, " press"},  {7'd0, key_press}, {7'd0, press});
        check({tag, " held"},   held, h);
    endtask

    task automatic expect_quiet(input string tag, input logic [7:0] h);
        check({tag, " strobe"}, {7'd0, key_strobe}, 8'h00);
        check({tag, " code"},   key_code, 8'h00);
        check({tag, " held"},   held, h);
    endtask

    initial begin
        Reset     = 1'b1;
        ps2_byte  = 8'h00;
        ps2_valid = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        expect_quiet("reset", 8'h00);
        check("reset press", {7'd0, key_press}, 8'h00);
        check("reset err",   {7'd0, err_timeout}, 8'h00);

        send(8'h1C); expect_event("make A", 8'h1C, 1'b1, 8'h80);
        tick();      expect_quiet("after make A", 8'h80);

        // Typematic repeats are suppressed, then the break clears the lane.
        send(8'h1C); expect_quiet("repeat A 1", 8'h80);
        send(8'h1C); expect_quiet("repeat A 2", 8'h80);
        send(8'hF0); expect_quiet("F0 prefix", 8'h80);
        send(8'h1C); expect_event("break A", 8'h1C, 1'b0, 8'h00);

        send(8'hE0); expect_quiet("E0", 8'h00);
        send(8'h4B); expect_quiet("E0 4B", 8'h00);
        send(8'hE0); expect_quiet("E0 b", 8'h00);
        send(8'hF0); expect_quiet("E0 F0", 8'h00);
        send(8'h4B); expect_quiet("E0 F0 4B", 8'h00);
        send(8'hAA); expect_quiet("BAT ignored", 8'h00);
        send(8'h15); expect_quiet("non-lane", 8'h00);
        send(8'h4B); expect_event("make L", 8'h4B, 1'b1, 8'h02);
        send(8'hF0);
        send(8'h4B); expect_event("break L", 8'h4B, 1'b0, 8'h00);
        tick();

        // Back-to-back bytes on consecutive cycles.
        send(8'h23); expect_event("b2b make D", 8'h23, 1'b1, 8'h20);
        send(8'h2B); expect_event("b2b make F", 8'h2B, 1'b1, 8'h30);
        send(8'hF0); expect_quiet("b2b F0", 8'h30);
        send(8'h23); expect_event("b2b break D", 8'h23, 1'b0, 8'h10);
        tick();      expect_quiet("b2b idle", 8'h10);

        // Abort after 16 idle cycles in BRK.
        send(8'hF0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("timeout early", {7'd0, err_timeout}, 8'h00);
        end
        tick();
        check("timeout pulse", {7'd0, err_timeout}, 8'h01);
        check("timeout no strobe", {7'd0, key_strobe}, 8'h00);
        tick();
        check("timeout one cycle", {7'd0, err_timeout}, 8'h00);
        send(8'h42); expect_event("make K after abort", 8'h42, 1'b1, 8'h14);

        // A byte on the expiry cycle is processed as the break.
        send(8'hF0);
        for (int i = 1; i <= 15; i++) tick();
        send(8'h2B);
        expect_event("byte wins expiry", 8'h2B, 1'b0, 8'h04);
        check("byte wins no err", {7'd0, err_timeout}, 8'h00);
        tick();
        check("byte wins no late err", {7'd0, err_timeout}, 8'h00);

        // Reset mid-sequence drops the pending break prefix.
        send(8'hF0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        expect_quiet("mid reset", 8'h00);
        send(8'h3B); expect_event("make J after reset", 8'h3B, 1'b1, 8'h08);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
